instruction_prefetch_queue: RTL
===============================

# instruction_prefetch_queue

Decoupling queue between the instruction fetch stage and the instruction decode stage. Captures each fetched {pc, instruction} pair into a small circular buffer and presents them in order to decode with a valid/ready handshake. Back-pressures fetch through its freeze input when full, and discards all buffered entries when a branch is taken. Decode stalls therefore do not stall fetch until the buffer fills.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- flush  input  1  branch taken; discards all entries (wired to fetch branch_taken)
- in_valid  input  1  fetch presents a valid pair this cycle
- in_pc  input  32  fetch o_pc (PC+4 of the fetched instruction)
- in_instruction  input  32  fetched instruction word
- freeze_fetch  output  1  queue full; drives fetch freeze
- out_valid  output  1  head entry available to decode
- out_pc  output  32  head entry pc
- out_instruction  output  32  head entry instruction
- out_ready  input  1  decode accepts head entry this cycle
- occupancy  output  $clog2(DEPTH)+1  number of valid entries

## Operation
- Storage: DEPTH × 64-bit entries {pc, instruction}; write pointer, read pointer (each $clog2(DEPTH) bits, wrap modulo DEPTH), count register of $clog2(DEPTH)+1 bits.
- full = (count == DEPTH); empty = (count == 0).
- push = in_valid & ~full & ~flush; writes entry at wr_ptr, wr_ptr+1.
- pop = out_valid & out_ready; rd_ptr+1.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push while full is dropped with no state change; fetch is frozen, so it holds and re-presents the same pair.
- Push and pop in the same cycle at full: push rejected. full is computed from the current count, and there is no pass-through.
- Push while empty: entry is not visible until the next cycle. No combinational bypass.
- flush (priority over everything): on the edge, wr_ptr = rd_ptr = count = 0. Concurrent push and pop are ignored.
- out_valid = ~empty & ~flush.
- out_pc and out_instruction = head entry when out_valid is 1, otherwise 32'h0.
- freeze_fetch = full. It depends on registered state only, with no combinational path from any input.
- occupancy = count.

## Timing
- reset low (asynchronous): pointers, count and storage clear to 0. out_valid=0, out_pc=0, out_instruction=0, freeze_fetch=0, occupancy=0. These hold while reset is low.
- Reset asserted mid-operation clears everything immediately. No entry survives.
- First cycle after reset deassertion: queue empty, ready to accept.
- Latency: a pair pushed at edge N is at the head, with out_valid=1, in the cycle after edge N if the queue was empty.
- Throughput: one push and one pop per cycle sustained. count is steady when both occur.
- freeze_fetch rises in the cycle after the push that makes count = DEPTH. It falls in the cycle after the first pop from full.
- flush at edge N: out_valid=0 during the flush cycle (combinational). occupancy=0 after edge N. The first post-flush push (branch target) is visible after edge N+1.
- Pointer wrap: DEPTH−1 → 0 with no gap or bubble.

## Test plan
- Reset: hold reset=0 with random inputs → all outputs 0. Release → occupancy=0, freeze_fetch=0.
- Fill without pop (out_ready=0, in_pc=4,8,12,16,20, in_valid=1): freeze_fetch=1 after the 4th edge. The 5th pair (pc 20) is not stored. Then out_ready=1 drains pc 4,8,12,16 in order, with freeze_fetch=0 after the first pop.
- Streaming with wrap: in_valid=1 and out_ready=1 for 10 cycles with pc 4..40 → out_pc 4..40 in order, each one cycle after push. occupancy stays 1 and freeze_fetch=0.
- Simultaneous push/pop at count=2 → count stays 2 and order is preserved. Same at count=4 → push rejected, count drops to 3.
- Flush with in_valid=1 and out_ready=1 at count=3 → out_valid=0 in that cycle and occupancy=0 after the edge. Next push of pc 0x100 appears as out_pc=0x100 one cycle later.
- Reset mid-stream at count=2 (async, between edges) → outputs zero immediately. After release the old entries never reappear.

Source files
------------

// File: rtl/instruction_prefetch_queue.sv
// rtl/instruction_prefetch_queue.sv - fetch-to-decode circular prefetch queue with flush
module instruction_prefetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instruction,
  output logic                     freeze_fetch,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instruction,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // full is taken from the registered count, so a pop never frees a slot in the same cycle
  always_comb begin
    full      = (count == CW'(DEPTH));
    empty     = (count == '0);
    out_valid = ~empty & ~flush;
    push      = in_valid & ~full & ~flush;
    pop       = out_valid & out_ready;
  end

  always_comb begin
    out_pc          = 32'h0;
    out_instruction = 32'h0;
    if (out_valid) begin
      out_pc          = mem[rd_ptr][63:32];
      out_instruction = mem[rd_ptr][31:0];
    end
  end

  assign freeze_fetch = full;
  assign occupancy    = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_pc, in_instruction};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
